// File: rtl/four_input_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : four_input_rr_mux_arbiter
// Description : Round-robin arbiter in front of a shared 4:1 mux. Turns a
//               4-bit request vector into a registered one-hot grant and
//               drives the mux select pair (s1,s0) to the granted index.
//               A bounded hold window stops any one requester from starving
//               the others.
// Ports       : clk    - system clock, rising edge
//               reset  - synchronous active-high reset
//               req    - request vector, req[i] asks for mux input i
//               grant  - registered one-hot grant, 0 when idle
//               s0, s1 - registered mux select, {s1,s0} = granted index
//               valid  - high while a grant is active
// Revision    : 1.0 - initial release
// ============================================================================
module four_input_rr_mux_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       s0,
    output logic       s1,
    output logic       valid
);

    localparam int             c_CW       = $clog2(HOLD_MAX + 1);
    localparam logic [c_CW-1:0] c_HOLD_MAX = c_CW'(HOLD_MAX);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [3:0]      r_grant,    w_grant_nxt;
    logic [1:0]      r_sel,      w_sel_nxt;
    logic [1:0]      r_last,     w_last_nxt;
    logic [c_CW-1:0] r_hold_cnt, w_hold_cnt_nxt;

    logic [3:0]      w_gnt_mask;
    logic [3:0]      w_others;
    logic            w_release;
    logic [3:0]      w_search_req;
    logic [1:0]      w_search_ptr;
    logic [2:0]      w_pick;

    // Returns {found, index}: first set bit of r scanning ptr, ptr+1, ...
    // with 2-bit wrap. Scanning from the far end lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    // In GRANT, r_sel always holds the index of the current winner.
    assign w_gnt_mask = 4'b0001 << r_sel;
    assign w_others   = req & ~w_gnt_mask;
    assign w_release  = (r_state == GRANT) &&
                        (!req[r_sel] ||
                         ((r_hold_cnt == c_HOLD_MAX) && (w_others != 4'b0000)));

    // Idle search starts after the last released index; a release search
    // starts after the releasing index and excludes it.
    assign w_search_req = (r_state == GRANT) ? w_others : req;
    assign w_search_ptr = (r_state == GRANT) ? (r_sel + 2'd1) : (r_last + 2'd1);
    assign w_pick       = rr_pick(w_search_req, w_search_ptr);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_sel_nxt      = r_sel;
        w_last_nxt     = r_last;
        w_hold_cnt_nxt = r_hold_cnt;

        unique case (r_state)
            IDLE: begin
                if (w_pick[2]) begin
                    w_state_nxt    = GRANT;
                    w_grant_nxt    = 4'b0001 << w_pick[1:0];
                    w_sel_nxt      = w_pick[1:0];
                    w_hold_cnt_nxt = c_ONE;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_last_nxt = r_sel;
                    if (w_pick[2]) begin
                        w_grant_nxt    = 4'b0001 << w_pick[1:0];
                        w_sel_nxt      = w_pick[1:0];
                        w_hold_cnt_nxt = c_ONE;
                    end else begin
                        // Select lines keep the last index while idle.
                        w_state_nxt    = IDLE;
                        w_grant_nxt    = 4'b0000;
                        w_hold_cnt_nxt = '0;
                    end
                end else if (r_hold_cnt < c_HOLD_MAX) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_ONE;
                end else begin
                    // Window expired with nobody waiting: restart it.
                    w_hold_cnt_nxt = c_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= 4'b0000;
            r_sel      <= 2'b00;
            r_last     <= 2'd3;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign grant = r_grant;
    assign s0    = r_sel[0];
    assign s1    = r_sel[1];
    assign valid = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_four_input_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_input_rr_mux_arbiter
// Description : Directed self-checking bench for four_input_rr_mux_arbiter.
//               One instance with HOLD_MAX=4, one with HOLD_MAX=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_input_rr_mux_arbiter;

    logic       clk;
    logic       reset0, reset1;
    logic [3:0] req0, req1;
    logic [3:0] grant0, grant1;
    logic       s0_0, s1_0, valid0;
    logic       s0_1, s1_1, valid1;

    int n_cmp;
    int n_bad;

    four_input_rr_mux_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk   (clk),
        .reset (reset0),
        .req   (req0),
        .grant (grant0),
        .s0    (s0_0),
        .s1    (s1_0),
        .valid (valid0)
    );

    four_input_rr_mux_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .req   (req1),
        .grant (grant1),
        .s0    (s0_1),
        .s1    (s1_1),
        .valid (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full check of the HOLD_MAX=4 instance.
    task automatic chk4(input string tag, input logic [3:0] g,
                        input logic [1:0] sel, input logic v);
        check_eq({tag, ".grant"}, {4'h0, grant0}, {4'h0, g});
        check_eq({tag, ".sel"},   {6'h0, s1_0, s0_0}, {6'h0, sel});
        check_eq({tag, ".valid"}, {7'h0, valid0}, {7'h0, v});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_g;
        n_cmp  = 0;
        n_bad  = 0;
        reset0 = 1'b1;
        reset1 = 1'b1;
        req0   = 4'b0000;
        req1   = 4'b0000;
        tick();
        tick();
        chk4("reset", 4'b0000, 2'b00, 1'b0);
        reset0 = 1'b0;

        // 1: single requester, one-cycle latency
        req0 = 4'b0001;
        tick();
        chk4("t1", 4'b0001, 2'b00, 1'b1);

        // 2: all request; input 0 already has hold_cnt=1
        req0 = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("t2.g0", 4'b0001, 2'b00, 1'b1);
        end
        for (int j = 1; j <= 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                exp_g = 4'b0001 << (j % 4);
                chk4("t2.rot", exp_g, 2'(j % 4), 1'b1);
            end
        end

        // 3: lone requester 2 keeps grant across window restarts
        req0 = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk4("t3", 4'b0100, 2'b10, 1'b1);
        end

        // 4: move to 1, then 3, then drop all
        req0 = 4'b0010;
        tick();
        chk4("t4.g1", 4'b0010, 2'b01, 1'b1);
        req0 = 4'b1000;
        tick();
        chk4("t4.g3", 4'b1000, 2'b11, 1'b1);
        req0 = 4'b0000;
        tick();
        chk4("t4.idle", 4'b0000, 2'b11, 1'b0);

        // 5: make last=2, then req=0101 from idle
        req0 = 4'b0100;
        tick();
        chk4("t5.g2", 4'b0100, 2'b10, 1'b1);
        req0 = 4'b0000;
        tick();
        chk4("t5.idle", 4'b0000, 2'b10, 1'b0);
        req0 = 4'b0101;
        tick();
        chk4("t5.ptr", 4'b0001, 2'b00, 1'b1);

        // 5b: HOLD_MAX=1 alternates every cycle
        reset1 = 1'b0;
        req1   = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            check_eq("t5b.grant", {4'h0, grant1}, {4'h0, exp_g});
            check_eq("t5b.sel", {6'h0, s1_1, s0_1},
                     (i % 2 == 0) ? 8'h00 : 8'h02);
            check_eq("t5b.valid", {7'h0, valid1}, 8'h01);
        end

        // 6: reset mid-grant restores pointer
        req0 = 4'b1000;
        tick();
        chk4("t6.g3", 4'b1000, 2'b11, 1'b1);
        reset0 = 1'b1;
        tick();
        chk4("t6.rst", 4'b0000, 2'b00, 1'b0);
        reset0 = 1'b0;
        req0   = 4'b1111;
        tick();
        chk4("t6.ptr", 4'b0001, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
